// File: rtl/ftdi_loader.sv
// ftdi_loader: frame parser and memory-write sequencer behind the FTDI RX FIFO.
//
// Pops bytes from the FIFO one at a time and hunts for SYNC. It then reads a
// 6-byte little-endian header (32-bit load address, 16-bit word count), packs
// the payload into little-endian 32-bit words and writes each one to memory
// over a req/ack handshake. A trailing checksum byte ends the frame: the 8-bit
// sum of every byte after SYNC, including the checksum itself, must be zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   empty, rd_en, din     FIFO side; din is valid the cycle after rd_en
//   mem_req, mem_addr,    memory write; request and payload are held
//   mem_wdata, mem_ack    until a single-cycle ack
//   busy                  frame in progress (any state other than sync hunt)
//   done                  one-cycle pulse at the end of each frame
//   err                   checksum error flag for the last frame
//   load_addr             word-aligned header address of the last frame
module ftdi_loader #(
    parameter logic [7:0]  SYNC   = 8'hA5,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty,
    output logic              rd_en,
    input  logic [7:0]        din,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] load_addr
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              vld_q;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [31:0]       hdr_q, hdr_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] load_q, load_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              consume;
    logic [7:0]        sum_nxt;
    logic [15:0]       len_nxt;
    logic [ADDR_W-1:0] hdr_aligned;

    assign consume = (state_q == S_SYNC) || (state_q == S_HDR) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);

    // vld_q marks the byte in flight: it blocks a second pop until the
    // popped byte has been consumed, so rd_en never fires on two
    // consecutive cycles. Gating with rst_n keeps the pop quiet in reset.
    assign rd_en = rst_n & consume & ~empty & ~vld_q;

    assign sum_nxt     = sum_q + din;
    assign len_nxt     = {din, len_q[15:8]};
    assign hdr_aligned = ADDR_W'(hdr_q) & ~ADDR_W'(3);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
        addr_d  = addr_q;
        load_d  = load_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            S_SYNC: begin
                if (vld_q && din == SYNC) begin
                    state_d = S_HDR;
                    sum_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_HDR: begin
                if (vld_q) begin
                    sum_d = sum_nxt;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < 3'd4) begin
                        hdr_d = {din, hdr_q[31:8]};
                    end else begin
                        len_d = len_nxt;
                    end
                    // Address bytes are complete by the 6th header byte;
                    // the count still needs this byte, hence len_nxt.
                    if (cnt_q == 3'd5) begin
                        cnt_d   = '0;
                        load_d  = hdr_aligned;
                        addr_d  = hdr_aligned;
                        state_d = (len_nxt == '0) ? S_CSUM : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (vld_q) begin
                    sum_d   = sum_nxt;
                    wdata_d = {din, wdata_q[31:8]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    len_d   = len_q - 16'd1;
                    state_d = (len_q == 16'd1) ? S_CSUM : S_DATA;
                end
            end
            S_CSUM: begin
                if (vld_q) begin
                    sum_d   = sum_nxt;
                    err_d   = (sum_nxt != '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_SYNC;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            hdr_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            load_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= rd_en;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Request and pulses decode straight from the state register, so they
    // drop asynchronously with reset and ack ends the request next cycle.
    assign mem_req   = (state_q == S_WRITE);
    assign busy      = (state_q != S_SYNC);
    assign done      = (state_q == S_DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign load_addr = load_q;

endmodule

// File: tb/tb_ftdi_loader.sv
// Bench for ftdi_loader: frames are built from the frame format, expected
// writes and end-of-frame results are queued at stimulus time, and a monitor
// on the FIFO/memory side pops and compares as the DUT presents them.
module tb_ftdi_loader;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              empty;
    logic              rd_en;
    logic [7:0]        din;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] load_addr;

    ftdi_loader #(.SYNC(8'hA5), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .empty    (empty),
        .rd_en    (rd_en),
        .din      (din),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .load_addr(load_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic        e;
        logic [31:0] la;
        logic [31:0] nwr;
    } dn_t;

    wr_t         exp_wr[$];
    dn_t         exp_done[$];
    logic [7:0]  fifo[$];
    logic [31:0] pl[$];

    int          checks = 0;
    int          failures = 0;
    int unsigned wr_total = 0;
    int unsigned wr_exp_total = 0;
    bit          stall = 0, toggle_mode = 0, rand_stall = 0;
    bit          spurious = 0, hold_ack = 0, rd_prev = 0, done_prev = 0;
    int          first_delay = -1;
    int unsigned cur_delay = 0, req_cnt = 0, cyc = 0;
    logic [31:0] hold_addr, hold_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: memory/done side on the falling edge, FIFO side 1ns later
    // once rd_en has settled against the freshly driven empty.
    always @(negedge clk) begin : mon
        wr_t w;
        dn_t d;
        if (!rst_n) begin
            mem_ack   = 1'b0;
            req_cnt   = 0;
            rd_prev   = 1'b0;
            done_prev = 1'b0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (req_cnt == 0) begin
                    hold_addr = mem_addr;
                    hold_data = mem_wdata;
                    if (first_delay >= 0) begin
                        cur_delay   = first_delay;
                        first_delay = -1;
                    end else begin
                        cur_delay = $urandom_range(0, 3);
                    end
                end else begin
                    check("req_addr_stable", mem_addr, hold_addr);
                    check("req_data_stable", mem_wdata, hold_data);
                end
                if (!hold_ack && req_cnt == cur_delay) begin
                    mem_ack = 1'b1;
                    req_cnt = 0;
                    wr_total++;
                    check("write_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("write_addr", mem_addr, w.a);
                        check("write_data", mem_wdata, w.d);
                    end
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
                if (spurious && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
            end
            check("done_single_cycle", done & done_prev, 0);
            done_prev = done;
            if (done) begin
                check("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) begin
                    d = exp_done.pop_front();
                    check("err", err, d.e);
                    check("load_addr", load_addr, d.la);
                    check("write_count", wr_total, d.nwr);
                end
            end
        end
        cyc++;
        if (toggle_mode) begin
            if (cyc % 3 == 0) stall = !stall;
        end else if (rand_stall) begin
            stall = ($urandom_range(0, 3) == 0);
        end else begin
            stall = 1'b0;
        end
        empty = (fifo.size() == 0) || stall;
        #1;
        if (rst_n) begin
            check("rd_en_while_empty", rd_en & empty, 0);
            check("rd_en_back_to_back", rd_en & rd_prev, 0);
            check("rd_en_in_write", rd_en & mem_req, 0);
            check("rd_en_in_done", rd_en & done, 0);
            if (rd_en && fifo.size() != 0) din = fifo.pop_front();
            rd_prev = rd_en;
        end
    end

    // Builds one frame from pl[] and queues its expected effects.
    task automatic send_frame(input logic [31:0] a, input logic corrupt);
        logic [7:0]  s;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [15:0] n;
        n  = 16'(pl.size());
        wa = a & ~32'd3;
        s  = 8'h00;
        fifo.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            b = a[8*i +: 8];
            fifo.push_back(b);
            s = s + b;
        end
        fifo.push_back(n[7:0]);
        fifo.push_back(n[15:8]);
        s = s + n[7:0] + n[15:8];
        for (int i = 0; i < int'(n); i++) begin
            wd = pl[i];
            for (int j = 0; j < 4; j++) begin
                b = wd[8*j +: 8];
                fifo.push_back(b);
                s = s + b;
            end
            exp_wr.push_back('{a: wa + 32'(4 * i), d: wd});
        end
        cs = 8'h00 - s + {7'b0, corrupt};
        fifo.push_back(cs);
        wr_exp_total += n;
        exp_done.push_back('{e: (8'(s + cs) != 8'h00), la: wa, nwr: wr_exp_total});
    endtask

    task automatic good_frame(input logic corrupt);
        pl = {32'h44332211, 32'h88776655};
        send_frame(32'h80001000, corrupt);
    endtask

    task automatic push_garbage(input int unsigned n);
        logic [7:0] g;
        for (int unsigned i = 0; i < n; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            fifo.push_back(g);
        end
    endtask

    task automatic wait_idle(input string name, input int unsigned limit);
        int unsigned k;
        k = 0;
        while ((exp_done.size() != 0 || fifo.size() != 0 || busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, k < limit, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_load_addr"}, load_addr, 0);
    endtask

    initial begin
        int unsigned k;
        rst_n   = 1'b0;
        empty   = 1'b1;
        din     = 8'h00;
        mem_ack = 1'b0;
        fifo.push_back(8'h11);
        repeat (3) @(negedge clk);
        #3;
        check_all_zero("reset");
        fifo.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Good frame, ack right after request.
        first_delay = 0;
        good_frame(1'b0);
        wait_idle("good", 2000);

        // Bad checksum: writes still happen, err flags.
        good_frame(1'b1);
        wait_idle("badsum", 2000);

        // Garbage bytes before an empty frame.
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        fifo.push_back(8'h5A);
        pl.delete();
        send_frame(32'h00000000, 1'b0);
        wait_idle("garbage", 2000);

        // Backpressure: first ack held off 10 cycles, FIFO toggling empty.
        toggle_mode = 1'b1;
        first_delay = 10;
        good_frame(1'b0);
        wait_idle("backpressure", 4000);
        toggle_mode = 1'b0;

        // Reset while a write is pending, then replay.
        hold_ack = 1'b1;
        good_frame(1'b0);
        k = 0;
        while (!mem_req && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reset_wait_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        fifo.delete();
        exp_wr.delete();
        exp_done.delete();
        wr_total     = 0;
        wr_exp_total = 0;
        hold_ack     = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        good_frame(1'b0);
        wait_idle("replay", 2000);

        // Address wrap past the top of the address space.
        pl = {$urandom, $urandom};
        send_frame(32'hFFFFFFFC, 1'b0);
        wait_idle("wrap", 2000);

        // Random back-to-back frames with stalls, spurious acks, noise.
        rand_stall = 1'b1;
        spurious   = 1'b1;
        for (int f = 0; f < 25; f++) begin
            push_garbage($urandom_range(0, 3));
            pl.delete();
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) pl.push_back($urandom);
            send_frame($urandom, ($urandom_range(0, 3) == 0));
        end
        wait_idle("random", 30000);
        rand_stall = 1'b0;
        spurious   = 1'b0;

        repeat (4) @(negedge clk);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_done", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
